// File: rtl/imuldiv_muldiv_arbiter.sv
// Two-port round-robin front end sharing one iterative mul/div unit; an owner-tag FIFO
// routes each result back to its issuing port. Optional counters under IMULDIV_ARB_STATS_EN.
module imuldiv_muldiv_arbiter #(
  parameter int unsigned TAG_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [66:0] req0_msg,
  input  logic        req0_val,
  output logic        req0_rdy,
  output logic [63:0] resp0_msg,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  input  logic [66:0] req1_msg,
  input  logic        req1_val,
  output logic        req1_rdy,
  output logic [63:0] resp1_msg,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic [66:0] muldivreq_msg,
  output logic        muldivreq_val,
  input  logic        muldivreq_rdy,
  input  logic [63:0] muldivresp_msg,
  input  logic        muldivresp_val,
  output logic        muldivresp_rdy
`ifdef IMULDIV_ARB_STATS_EN
  ,
  output logic [31:0] grant_count0,
  output logic [31:0] grant_count1,
  output logic [31:0] conflict_count
`endif
);

  localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;

  logic                 prio_q;
  logic [TAG_DEPTH-1:0] tags_q;
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      count_q;

  logic grant, owner, empty, full, pop, can_push, fire;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CntW'(TAG_DEPTH));
    owner = tags_q[rd_ptr_q];

    // A lone requester wins regardless of prio; prio only breaks ties.
    grant = (req0_val && req1_val) ? prio_q : req1_val;

    muldivresp_rdy = reset_n && !empty && (owner ? resp1_rdy : resp0_rdy);
    pop            = muldivresp_val && muldivresp_rdy;
    can_push       = !full || pop;

    muldivreq_val = reset_n && (req0_val || req1_val) && can_push;
    muldivreq_msg = grant ? req1_msg : req0_msg;
    req0_rdy      = reset_n && !grant && muldivreq_rdy && can_push;
    req1_rdy      = reset_n && grant && muldivreq_rdy && can_push;
    fire          = muldivreq_val && muldivreq_rdy;

    resp0_val = reset_n && muldivresp_val && !empty && !owner;
    resp1_val = reset_n && muldivresp_val && !empty && owner;
    resp0_msg = muldivresp_msg;
    resp1_msg = muldivresp_msg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q   <= 1'b0;
      tags_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fire) begin
        tags_q[wr_ptr_q] <= grant;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        prio_q           <= !grant;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CntW'(fire) - CntW'(pop);
    end
  end

`ifdef IMULDIV_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_count0   <= '0;
      grant_count1   <= '0;
      conflict_count <= '0;
    end else begin
      if (fire && !grant) grant_count0 <= grant_count0 + 32'd1;
      if (fire && grant)  grant_count1 <= grant_count1 + 32'd1;
      if (req0_val && req1_val) conflict_count <= conflict_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A result with no outstanding tag means the unit broke the protocol.
  always_ff @(posedge clk) begin
    if (reset_n && muldivresp_val && empty) begin
      $display("imuldiv_muldiv_arbiter: unit response with no outstanding tag at %0t", $time);
    end
  end
`endif

endmodule
